// File: rtl/dma_param_regs_mc.sv
// Multi-channel Avalon-MM register file for the AI DMA engines.
// Optional DMA_PARAM_SHADOW_EN: parameters are staged and applied on start.
module dma_param_regs_mc #(
    parameter  int CH_BITS  = 1,
    parameter  int ADDR_W   = 32,
    parameter  int LEN_W    = 16,
    parameter  int COEF_W   = 8,
    localparam int CHANNELS = 2 ** CH_BITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       avs_s0_write,
    input  logic                       avs_s0_read,
    input  logic [CH_BITS+3:0]         avs_s0_address,
    input  logic [31:0]                avs_s0_writedata,
    output logic [31:0]                avs_s0_readdata,
    output logic                       avm_s0_irq,
    input  logic [CHANNELS-1:0]        done,
    output logic [CHANNELS-1:0]        start,
    output logic [CHANNELS-1:0]        busy,
    output logic [CHANNELS*ADDR_W-1:0] start_addr_block,
    output logic [CHANNELS*ADDR_W-1:0] stop_addr_block,
    output logic [CHANNELS*ADDR_W-1:0] start_addr_read,
    output logic [CHANNELS*LEN_W-1:0]  data_len,
    output logic [CHANNELS*LEN_W-1:0]  line_width,
    output logic [CHANNELS*LEN_W-1:0]  region_width,
    output logic [CHANNELS*COEF_W-1:0] minimum1,
    output logic [CHANNELS*COEF_W-1:0] minimum2,
    output logic [CHANNELS*COEF_W-1:0] wage1,
    output logic [CHANNELS*COEF_W-1:0] wage2,
    output logic [CHANNELS-1:0]        shift
);

    localparam logic [31:0] ID_VAL = 32'h444D_0200 | 32'(CHANNELS);

    // control / status state
    logic [CHANNELS-1:0] r_start;
    logic [CHANNELS-1:0] r_busy;
    logic [CHANNELS-1:0] r_pend;
    logic [CHANNELS-1:0] r_ip;
    logic [CHANNELS-1:0] r_ie;
    logic [31:0]         r_rdata;

    // active parameter registers driving the DMA cores
    logic [CHANNELS-1:0][ADDR_W-1:0] r_sab;
    logic [CHANNELS-1:0][ADDR_W-1:0] r_eab;
    logic [CHANNELS-1:0][ADDR_W-1:0] r_sar;
    logic [CHANNELS-1:0][LEN_W-1:0]  r_len;
    logic [CHANNELS-1:0][LEN_W-1:0]  r_lw;
    logic [CHANNELS-1:0][LEN_W-1:0]  r_rw;
    logic [CHANNELS-1:0][COEF_W-1:0] r_min1;
    logic [CHANNELS-1:0][COEF_W-1:0] r_min2;
    logic [CHANNELS-1:0][COEF_W-1:0] r_wg1;
    logic [CHANNELS-1:0][COEF_W-1:0] r_wg2;
    logic [CHANNELS-1:0]             r_shift;

    // register view seen by the bus on readback
    logic [CHANNELS-1:0][ADDR_W-1:0] w_q_sab;
    logic [CHANNELS-1:0][ADDR_W-1:0] w_q_eab;
    logic [CHANNELS-1:0][ADDR_W-1:0] w_q_sar;
    logic [CHANNELS-1:0][LEN_W-1:0]  w_q_len;
    logic [CHANNELS-1:0][LEN_W-1:0]  w_q_lw;
    logic [CHANNELS-1:0][LEN_W-1:0]  w_q_rw;
    logic [CHANNELS-1:0][COEF_W-1:0] w_q_min1;
    logic [CHANNELS-1:0][COEF_W-1:0] w_q_min2;
    logic [CHANNELS-1:0][COEF_W-1:0] w_q_wg1;
    logic [CHANNELS-1:0][COEF_W-1:0] w_q_wg2;
    logic [CHANNELS-1:0]             w_q_shift;

    logic [CH_BITS-1:0]  w_ch;
    logic [3:0]          w_off;
    logic [CHANNELS-1:0] w_sel;
    logic [CHANNELS-1:0] w_ctrl_wr;
    logic [CHANNELS-1:0] w_req;
    logic [CHANNELS-1:0] w_w1c;
    logic [CHANNELS-1:0] w_launch;
    logic [31:0]         w_rdata;

    assign w_ch  = avs_s0_address[CH_BITS+3:4];
    assign w_off = avs_s0_address[3:0];

    // per-channel write decode and start launch condition
    always_comb begin
        w_sel     = '0;
        w_ctrl_wr = '0;
        w_req     = '0;
        w_w1c     = '0;
        w_launch  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_sel[c]     = avs_s0_write && (w_ch == CH_BITS'(c));
            w_ctrl_wr[c] = w_sel[c] && (w_off == 4'd0);
            w_req[c]     = w_ctrl_wr[c] && avs_s0_writedata[0];
            w_w1c[c]     = w_ctrl_wr[c] && avs_s0_writedata[1];
            // a queued or same-cycle request restarts on done
            if (r_busy[c]) begin
                w_launch[c] = done[c] && (r_pend[c] || w_req[c]);
            end else begin
                w_launch[c] = w_req[c];
            end
        end
    end

    // start pulse, busy, 1-deep start queue and irq latches
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start <= '0;
            r_busy  <= '0;
            r_pend  <= '0;
            r_ip    <= '0;
            r_ie    <= '0;
        end else begin
            r_start <= w_launch;
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_ctrl_wr[c]) begin
                    r_ie[c] <= avs_s0_writedata[2];
                end
                if (r_busy[c] && done[c]) begin
                    r_ip[c] <= 1'b1;
                end else if (w_w1c[c]) begin
                    r_ip[c] <= 1'b0;
                end
                if (r_busy[c]) begin
                    if (done[c]) begin
                        r_pend[c] <= 1'b0;
                        if (!(r_pend[c] || w_req[c])) begin
                            r_busy[c] <= 1'b0;
                        end
                    end else if (w_req[c]) begin
                        r_pend[c] <= 1'b1;
                    end
                end else if (w_req[c]) begin
                    r_busy[c] <= 1'b1;
                end
            end
        end
    end

`ifdef DMA_PARAM_SHADOW_EN
    logic [CHANNELS-1:0][ADDR_W-1:0] r_s_sab;
    logic [CHANNELS-1:0][ADDR_W-1:0] r_s_eab;
    logic [CHANNELS-1:0][ADDR_W-1:0] r_s_sar;
    logic [CHANNELS-1:0][LEN_W-1:0]  r_s_len;
    logic [CHANNELS-1:0][LEN_W-1:0]  r_s_lw;
    logic [CHANNELS-1:0][LEN_W-1:0]  r_s_rw;
    logic [CHANNELS-1:0][COEF_W-1:0] r_s_min1;
    logic [CHANNELS-1:0][COEF_W-1:0] r_s_min2;
    logic [CHANNELS-1:0][COEF_W-1:0] r_s_wg1;
    logic [CHANNELS-1:0][COEF_W-1:0] r_s_wg2;
    logic [CHANNELS-1:0]             r_s_shift;

    // bus writes land in the shadow set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_sab   <= '0;
            r_s_eab   <= '0;
            r_s_sar   <= '0;
            r_s_len   <= '0;
            r_s_lw    <= '0;
            r_s_rw    <= '0;
            r_s_min1  <= '0;
            r_s_min2  <= '0;
            r_s_wg1   <= '0;
            r_s_wg2   <= '0;
            r_s_shift <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_sel[c]) begin
                    case (w_off)
                        4'd1: r_s_sab[c] <= avs_s0_writedata[ADDR_W-1:0];
                        4'd2: r_s_eab[c] <= avs_s0_writedata[ADDR_W-1:0];
                        4'd3: r_s_len[c] <= avs_s0_writedata[LEN_W-1:0];
                        4'd4: begin
                            r_s_min1[c]  <= avs_s0_writedata[COEF_W-1:0];
                            r_s_min2[c]  <= avs_s0_writedata[8 +: COEF_W];
                            r_s_shift[c] <= avs_s0_writedata[16];
                        end
                        4'd5: begin
                            r_s_wg1[c] <= avs_s0_writedata[COEF_W-1:0];
                            r_s_wg2[c] <= avs_s0_writedata[8 +: COEF_W];
                        end
                        4'd6: r_s_sar[c] <= avs_s0_writedata[ADDR_W-1:0];
                        4'd8: r_s_lw[c]  <= avs_s0_writedata[LEN_W-1:0];
                        4'd9: r_s_rw[c]  <= avs_s0_writedata[LEN_W-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // shadow copied to outputs on the edge that raises start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sab   <= '0;
            r_eab   <= '0;
            r_sar   <= '0;
            r_len   <= '0;
            r_lw    <= '0;
            r_rw    <= '0;
            r_min1  <= '0;
            r_min2  <= '0;
            r_wg1   <= '0;
            r_wg2   <= '0;
            r_shift <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_launch[c]) begin
                    r_sab[c]   <= r_s_sab[c];
                    r_eab[c]   <= r_s_eab[c];
                    r_sar[c]   <= r_s_sar[c];
                    r_len[c]   <= r_s_len[c];
                    r_lw[c]    <= r_s_lw[c];
                    r_rw[c]    <= r_s_rw[c];
                    r_min1[c]  <= r_s_min1[c];
                    r_min2[c]  <= r_s_min2[c];
                    r_wg1[c]   <= r_s_wg1[c];
                    r_wg2[c]   <= r_s_wg2[c];
                    r_shift[c] <= r_s_shift[c];
                end
            end
        end
    end

    assign w_q_sab   = r_s_sab;
    assign w_q_eab   = r_s_eab;
    assign w_q_sar   = r_s_sar;
    assign w_q_len   = r_s_len;
    assign w_q_lw    = r_s_lw;
    assign w_q_rw    = r_s_rw;
    assign w_q_min1  = r_s_min1;
    assign w_q_min2  = r_s_min2;
    assign w_q_wg1   = r_s_wg1;
    assign w_q_wg2   = r_s_wg2;
    assign w_q_shift = r_s_shift;
`else
    // bus writes update the outputs directly
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sab   <= '0;
            r_eab   <= '0;
            r_sar   <= '0;
            r_len   <= '0;
            r_lw    <= '0;
            r_rw    <= '0;
            r_min1  <= '0;
            r_min2  <= '0;
            r_wg1   <= '0;
            r_wg2   <= '0;
            r_shift <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_sel[c]) begin
                    case (w_off)
                        4'd1: r_sab[c] <= avs_s0_writedata[ADDR_W-1:0];
                        4'd2: r_eab[c] <= avs_s0_writedata[ADDR_W-1:0];
                        4'd3: r_len[c] <= avs_s0_writedata[LEN_W-1:0];
                        4'd4: begin
                            r_min1[c]  <= avs_s0_writedata[COEF_W-1:0];
                            r_min2[c]  <= avs_s0_writedata[8 +: COEF_W];
                            r_shift[c] <= avs_s0_writedata[16];
                        end
                        4'd5: begin
                            r_wg1[c] <= avs_s0_writedata[COEF_W-1:0];
                            r_wg2[c] <= avs_s0_writedata[8 +: COEF_W];
                        end
                        4'd6: r_sar[c] <= avs_s0_writedata[ADDR_W-1:0];
                        4'd8: r_lw[c]  <= avs_s0_writedata[LEN_W-1:0];
                        4'd9: r_rw[c]  <= avs_s0_writedata[LEN_W-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    assign w_q_sab   = r_sab;
    assign w_q_eab   = r_eab;
    assign w_q_sar   = r_sar;
    assign w_q_len   = r_len;
    assign w_q_lw    = r_lw;
    assign w_q_rw    = r_rw;
    assign w_q_min1  = r_min1;
    assign w_q_min2  = r_min2;
    assign w_q_wg1   = r_wg1;
    assign w_q_wg2   = r_wg2;
    assign w_q_shift = r_shift;
`endif

    // readback mux over the addressed channel
    always_comb begin
        w_rdata = '0;
        case (w_off)
            4'd0: w_rdata = {28'b0, r_pend[w_ch], r_ie[w_ch],
                             r_ip[w_ch], r_busy[w_ch]};
            4'd1: w_rdata = 32'(w_q_sab[w_ch]);
            4'd2: w_rdata = 32'(w_q_eab[w_ch]);
            4'd3: w_rdata = 32'(w_q_len[w_ch]);
            4'd4: w_rdata = {15'b0, w_q_shift[w_ch],
                             8'(w_q_min2[w_ch]), 8'(w_q_min1[w_ch])};
            4'd5: w_rdata = {16'b0, 8'(w_q_wg2[w_ch]), 8'(w_q_wg1[w_ch])};
            4'd6: w_rdata = 32'(w_q_sar[w_ch]);
            4'd8: w_rdata = 32'(w_q_lw[w_ch]);
            4'd9: w_rdata = 32'(w_q_rw[w_ch]);
            4'd15: w_rdata = ID_VAL;
            default: w_rdata = '0;
        endcase
    end

    // read data registered one cycle after the strobe, held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (avs_s0_read) begin
            r_rdata <= w_rdata;
        end
    end

    assign avs_s0_readdata  = r_rdata;
    assign avm_s0_irq       = |(r_ip & r_ie);
    assign start            = r_start;
    assign busy             = r_busy;
    assign start_addr_block = r_sab;
    assign stop_addr_block  = r_eab;
    assign start_addr_read  = r_sar;
    assign data_len         = r_len;
    assign line_width       = r_lw;
    assign region_width     = r_rw;
    assign minimum1         = r_min1;
    assign minimum2         = r_min2;
    assign wage1            = r_wg1;
    assign wage2            = r_wg2;
    assign shift            = r_shift;

endmodule

// File: tb/tb_dma_param_regs_mc.sv
// Testbench for dma_param_regs_mc: directed table, corner sequences,
// and random traffic against a register-map reference model.
module tb_dma_param_regs_mc;

    localparam int CH_BITS  = 1;
    localparam int CHANNELS = 2;
    localparam int ADDR_W   = 32;
    localparam int LEN_W    = 16;
    localparam int COEF_W   = 8;
`ifdef DMA_PARAM_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr = 1'b0;
    logic rd = 1'b0;
    logic [CH_BITS+3:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic irq;
    logic [CHANNELS-1:0] dn = '0;
    logic [CHANNELS-1:0] st;
    logic [CHANNELS-1:0] bsy;
    logic [CHANNELS*ADDR_W-1:0] sab, eab, sar;
    logic [CHANNELS*LEN_W-1:0] len, lw, rw;
    logic [CHANNELS*COEF_W-1:0] mn1, mn2, wg1, wg2;
    logic [CHANNELS-1:0] shf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dma_param_regs_mc #(
        .CH_BITS(CH_BITS), .ADDR_W(ADDR_W),
        .LEN_W(LEN_W), .COEF_W(COEF_W)
    ) dut (
        .clk(clk), .rst(rst),
        .avs_s0_write(wr), .avs_s0_read(rd),
        .avs_s0_address(addr), .avs_s0_writedata(wdata),
        .avs_s0_readdata(rdata), .avm_s0_irq(irq),
        .done(dn), .start(st), .busy(bsy),
        .start_addr_block(sab), .stop_addr_block(eab),
        .start_addr_read(sar), .data_len(len),
        .line_width(lw), .region_width(rw),
        .minimum1(mn1), .minimum2(mn2),
        .wage1(wg1), .wage2(wg2), .shift(shf)
    );

    // Reference model: each channel is a 16-word register map plus flags.
    bit          m_busy [CHANNELS];
    bit          m_pend [CHANNELS];
    bit          m_ip   [CHANNELS];
    bit          m_ie   [CHANNELS];
    bit          m_start[CHANNELS];
    logic [31:0] m_shd  [CHANNELS][16];
    logic [31:0] m_act  [CHANNELS][16];
    logic [31:0] m_rdata;

    function automatic logic [31:0] fmask(int off);
        case (off)
            1, 2, 6: return 32'hFFFF_FFFF;
            3, 8, 9: return 32'h0000_FFFF;
            4:       return 32'h0001_FFFF;
            5:       return 32'h0000_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(int ch, int off);
        if (off == 0)
            return {28'b0, m_pend[ch], m_ie[ch], m_ip[ch], m_busy[ch]};
        if (off == 15)
            return 32'h444D_0200 | CHANNELS;
        return (SHADOW ? m_shd[ch][off] : m_act[ch][off]) & fmask(off);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CHANNELS; c++) begin
            m_busy[c] = 0; m_pend[c] = 0; m_ip[c] = 0;
            m_ie[c] = 0; m_start[c] = 0;
            for (int o = 0; o < 16; o++) begin
                m_shd[c][o] = '0; m_act[c][o] = '0;
            end
        end
        m_rdata = '0;
    endtask

    task automatic model_step(bit w, bit r, logic [CH_BITS+3:0] a,
                              logic [31:0] d, logic [CHANNELS-1:0] dv);
        int ch, off;
        bit req, go, fin;
        ch  = int'(a[CH_BITS+3:4]);
        off = int'(a[3:0]);
        if (r) m_rdata = m_read(ch, off);
        for (int c = 0; c < CHANNELS; c++) begin
            req = w && (ch == c) && (off == 0) && d[0];
            fin = m_busy[c] && dv[c];
            if (!m_busy[c]) go = req;
            else            go = fin && (m_pend[c] || req);
            m_start[c] = go;
            if (w && ch == c && off == 0) m_ie[c] = d[2];
            if (fin) m_ip[c] = 1;
            else if (w && ch == c && off == 0 && d[1]) m_ip[c] = 0;
            if (fin) begin
                m_pend[c] = 0;
                m_busy[c] = go;
            end else if (m_busy[c]) begin
                if (req) m_pend[c] = 1;
            end else begin
                m_busy[c] = req;
            end
            if (SHADOW && go)
                for (int o = 0; o < 16; o++) m_act[c][o] = m_shd[c][o];
        end
        if (w && fmask(off) != 0) begin
            if (SHADOW) m_shd[ch][off] = d & fmask(off);
            else        m_act[ch][off] = d & fmask(off);
        end
    endtask

    task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [CHANNELS-1:0] e_st, e_bsy, e_shf;
        logic [CHANNELS*ADDR_W-1:0] e_sab, e_eab, e_sar;
        logic [CHANNELS*LEN_W-1:0] e_len, e_lw, e_rw;
        logic [CHANNELS*COEF_W-1:0] e_mn1, e_mn2, e_wg1, e_wg2;
        bit e_irq;
        e_irq = 0;
        for (int c = 0; c < CHANNELS; c++) begin
            e_st[c]  = m_start[c];
            e_bsy[c] = m_busy[c];
            e_irq    = e_irq | (m_ip[c] & m_ie[c]);
            e_sab[c*ADDR_W +: ADDR_W] = m_act[c][1];
            e_eab[c*ADDR_W +: ADDR_W] = m_act[c][2];
            e_sar[c*ADDR_W +: ADDR_W] = m_act[c][6];
            e_len[c*LEN_W +: LEN_W]   = m_act[c][3][15:0];
            e_lw[c*LEN_W +: LEN_W]    = m_act[c][8][15:0];
            e_rw[c*LEN_W +: LEN_W]    = m_act[c][9][15:0];
            e_mn1[c*COEF_W +: COEF_W] = m_act[c][4][7:0];
            e_mn2[c*COEF_W +: COEF_W] = m_act[c][4][15:8];
            e_shf[c]                  = m_act[c][4][16];
            e_wg1[c*COEF_W +: COEF_W] = m_act[c][5][7:0];
            e_wg2[c*COEF_W +: COEF_W] = m_act[c][5][15:8];
        end
        chk("start", st, e_st);
        chk("busy", bsy, e_bsy);
        chk("irq", irq, e_irq);
        chk("readdata", rdata, m_rdata);
        chk("start_addr_block", sab, e_sab);
        chk("stop_addr_block", eab, e_eab);
        chk("start_addr_read", sar, e_sar);
        chk("data_len", len, e_len);
        chk("line_width", lw, e_lw);
        chk("region_width", rw, e_rw);
        chk("minimum1", mn1, e_mn1);
        chk("minimum2", mn2, e_mn2);
        chk("wage1", wg1, e_wg1);
        chk("wage2", wg2, e_wg2);
        chk("shift", shf, e_shf);
    endtask

    task automatic cycle(bit w, bit r, logic [CH_BITS+3:0] a,
                         logic [31:0] d, logic [CHANNELS-1:0] dv, bit rs);
        @(negedge clk);
        wr = w; rd = r; addr = a; wdata = d; dn = dv; rst = rs;
        @(posedge clk);
        if (rs) model_reset();
        else    model_step(w, r, a, d, dv);
        #1;
        compare_all();
    endtask

    typedef struct {
        bit                  w;
        bit                  r;
        logic [CH_BITS+3:0]  a;
        logic [31:0]         d;
        logic [CHANNELS-1:0] dv;
        bit                  has_exp;
        logic [31:0]         exp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        model_reset();
        tbl.push_back('{0, 1, 5'h1F, 32'h0,          2'b00, 1, 32'h444D_0202});
        tbl.push_back('{0, 1, 5'h00, 32'h0,          2'b00, 1, 32'h0});
        tbl.push_back('{1, 0, 5'h01, 32'h0000_1000,  2'b00, 0, 32'h0});
        tbl.push_back('{1, 0, 5'h04, 32'h0001_0305,  2'b00, 0, 32'h0});
        tbl.push_back('{1, 0, 5'h00, 32'h1,          2'b00, 0, 32'h0});
        tbl.push_back('{0, 0, 5'h00, 32'h0,          2'b00, 0, 32'h0});
        tbl.push_back('{1, 0, 5'h00, 32'h1,          2'b00, 0, 32'h0});
        tbl.push_back('{1, 0, 5'h00, 32'h1,          2'b00, 0, 32'h0});
        tbl.push_back('{0, 1, 5'h00, 32'h0,          2'b00, 1, 32'h9});
        tbl.push_back('{0, 0, 5'h00, 32'h0,          2'b01, 0, 32'h0});
        tbl.push_back('{0, 0, 5'h00, 32'h0,          2'b00, 0, 32'h0});
        tbl.push_back('{0, 0, 5'h00, 32'h0,          2'b01, 0, 32'h0});
        tbl.push_back('{0, 1, 5'h00, 32'h0,          2'b00, 1, 32'h2});
        tbl.push_back('{1, 0, 5'h10, 32'h4,          2'b00, 0, 32'h0});
        tbl.push_back('{1, 0, 5'h10, 32'h5,          2'b00, 0, 32'h0});
        tbl.push_back('{0, 0, 5'h00, 32'h0,          2'b10, 0, 32'h0});
        tbl.push_back('{1, 0, 5'h10, 32'h5,          2'b00, 0, 32'h0});
        tbl.push_back('{1, 0, 5'h10, 32'h6,          2'b10, 0, 32'h0});
        tbl.push_back('{1, 0, 5'h10, 32'h6,          2'b00, 0, 32'h0});
        tbl.push_back('{0, 1, 5'h10, 32'h0,          2'b00, 1, 32'h4});
        tbl.push_back('{1, 1, 5'h01, 32'h0000_2222,  2'b00, 1, 32'h0000_1000});
        tbl.push_back('{0, 1, 5'h01, 32'h0,          2'b00, 1, 32'h0000_2222});
        tbl.push_back('{1, 0, 5'h07, 32'hFFFF_FFFF,  2'b00, 0, 32'h0});
        tbl.push_back('{0, 1, 5'h07, 32'h0,          2'b00, 1, 32'h0});
        tbl.push_back('{0, 1, 5'h11, 32'h0,          2'b00, 1, 32'h0});
        tbl.push_back('{0, 1, 5'h04, 32'h0,          2'b00, 1, 32'h0001_0305});
        tbl.push_back('{1, 0, 5'h05, 32'hABCD_1234,  2'b00, 0, 32'h0});
        tbl.push_back('{0, 1, 5'h05, 32'h0,          2'b00, 1, 32'h0000_1234});
        tbl.push_back('{0, 1, 5'h0F, 32'h0,          2'b00, 1, 32'h444D_0202});

        cycle(0, 0, '0, '0, '0, 1);
        cycle(0, 0, '0, '0, '0, 1);
        chk("reset_busy", bsy, '0);
        chk("reset_readdata", rdata, '0);

        foreach (tbl[i]) begin
            cycle(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].dv, 0);
            if (tbl[i].has_exp) chk($sformatf("tbl_rd[%0d]", i), rdata, tbl[i].exp);
        end

        // staged parameter write while running, applied on queued start
        cycle(1, 0, 5'h00, 32'h1, 2'b00, 0);
        cycle(1, 0, 5'h00, 32'h1, 2'b00, 0);
        cycle(1, 0, 5'h03, 32'h0000_00FF, 2'b00, 0);
        cycle(0, 0, 5'h00, 32'h0, 2'b00, 0);
        cycle(0, 0, 5'h00, 32'h0, 2'b01, 0);
        chk("queued_start", st[0], 1'b1);
        cycle(0, 0, 5'h00, 32'h0, 2'b00, 0);
        chk("data_len_after", len[15:0], 16'h00FF);

        // reset while busy with a queued start; later done is ignored
        cycle(1, 0, 5'h00, 32'h1, 2'b00, 0);
        cycle(0, 0, 5'h00, 32'h0, 2'b00, 1);
        chk("rst_busy", bsy, '0);
        chk("rst_irq", irq, 1'b0);
        cycle(0, 0, 5'h00, 32'h0, 2'b11, 0);
        cycle(0, 1, 5'h00, 32'h0, 2'b00, 0);
        chk("post_rst_start", st, '0);
        chk("post_rst_ctrl", rdata, 32'h0);

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [CH_BITS+3:0] ra;
            logic [31:0] rwd;
            logic [CHANNELS-1:0] rdn;
            bit rrs;
            ra[CH_BITS+3:4] = CH_BITS'($urandom_range(0, CHANNELS - 1));
            ra[3:0] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            rwd = $urandom;
            for (int c = 0; c < CHANNELS; c++) rdn[c] = ($urandom_range(0, 3) == 0);
            rrs = ($urandom_range(0, 299) == 0);
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rwd, rdn, rrs);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
